avlstrm_pkt_rr_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter. Merges NUM_IN Avalon-ST packet streams, typically the out sides of per-source unified FIFO wrappers, into one output stream.
- The output feeds a shared downstream FIFO. The downstream almost-full flag throttles new packet grants.
- Once a packet is granted, all of its flits are forwarded contiguously. Output goes through a registered 2-entry skid buffer for timing closure.

---
 rtl/avlstrm_pkt_rr_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_avlstrm_pkt_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avlstrm_pkt_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN Avalon-ST streams into one output.
// Granted packets pass contiguously through a registered 2-entry skid buffer.
module avlstrm_pkt_rr_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int GRANT_W     = $clog2(NUM_IN)
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN-1:0]             in_sop,
  input  logic [NUM_IN-1:0]             in_eop,
  input  logic [NUM_IN*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_IN-1:0]             in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [EMPTY_WIDTH-1:0]        out_empty,
  input  logic                          out_ready,
  input  logic                          out_almost_full,
  output logic [GRANT_W-1:0]            cur_grant,
  output logic                          busy,
  output logic [31:0]                   stats_pkt,
  output logic [31:0]                   stats_sop_err
);

  localparam int FLIT_W = DATA_WIDTH + EMPTY_WIDTH + 2;
  localparam int SUM_W  = GRANT_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [FLIT_W-1:0]    head_q, head_d;
  logic [FLIT_W-1:0]    tail_q, tail_d;
  logic                 head_vld_q, head_vld_d;
  logic                 tail_vld_q, tail_vld_d;
  logic                 skid_ready_q, skid_ready_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic [31:0]          err_cnt_q, err_cnt_d;

  logic [DATA_WIDTH-1:0]  in_data_a  [NUM_IN];
  logic [EMPTY_WIDTH-1:0] in_empty_a [NUM_IN];
  logic [NUM_IN-1:0]      req;
  logic [NUM_IN-1:0]      sop_err;

  logic [SUM_W-1:0]   rr_sum;
  logic [GRANT_W-1:0] rr_cand;
  logic [GRANT_W-1:0] rr_pick;
  logic               rr_found;
  logic [GRANT_W-1:0] drain_idx;
  logic               drain_found;

  logic              push;
  logic              pop;
  logic              drain_xfer;
  logic [FLIT_W-1:0] push_flit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign in_data_a[gi]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_empty_a[gi] = in_empty[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
      assign req[gi]        = in_valid[gi] & in_sop[gi];
      assign sop_err[gi]    = in_valid[gi] & ~in_sop[gi];
    end
  endgenerate

  // Scan last_grant+1, last_grant+2, ... wrapping at NUM_IN (need not be a power of 2).
  always_comb begin
    rr_pick  = grant_q;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_sum = {1'b0, grant_q} + SUM_W'(k);
      if (rr_sum >= SUM_W'(NUM_IN)) begin
        rr_sum = rr_sum - SUM_W'(NUM_IN);
      end
      rr_cand = rr_sum[GRANT_W-1:0];
      if (!rr_found && req[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    drain_idx   = '0;
    drain_found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!drain_found && sop_err[i]) begin
        drain_idx   = GRANT_W'(i);
        drain_found = 1'b1;
      end
    end
  end

  // FSM next state; a grant is taken only between packets.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (!out_almost_full && rr_found) begin
          state_d = ST_PKT;
          grant_d = rr_pick;
        end
      end
      ST_PKT: begin
        if (in_valid[grant_q] && skid_ready_q && in_eop[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = '0;
    busy       = 1'b0;
    push       = 1'b0;
    drain_xfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_found) begin
          in_ready[drain_idx] = 1'b1;
          drain_xfer          = 1'b1;
        end
      end
      ST_PKT: begin
        busy              = 1'b1;
        in_ready[grant_q] = skid_ready_q;
        push              = in_valid[grant_q] & skid_ready_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign push_flit = {in_sop[grant_q], in_eop[grant_q], in_empty_a[grant_q], in_data_a[grant_q]};
  assign pop       = head_vld_q & out_ready;

  // Head is the output register; tail only fills when the head is stalled.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end
    if (push) begin
      if (!head_vld_d) begin
        head_d     = push_flit;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = push_flit;
        tail_vld_d = 1'b1;
      end
    end
    skid_ready_d = ~(head_vld_d & tail_vld_d);
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pop && head_q[FLIT_W-2]) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (drain_xfer) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_W'(NUM_IN - 1);
      head_q       <= '0;
      tail_q       <= '0;
      head_vld_q   <= 1'b0;
      tail_vld_q   <= 1'b0;
      skid_ready_q <= 1'b1;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_vld_q   <= head_vld_d;
      tail_vld_q   <= tail_vld_d;
      skid_ready_q <= skid_ready_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_data      = head_q[DATA_WIDTH-1:0];
  assign out_empty     = head_q[DATA_WIDTH +: EMPTY_WIDTH];
  assign out_eop       = head_q[FLIT_W-2];
  assign out_sop       = head_q[FLIT_W-1];
  assign out_valid     = head_vld_q;
  assign cur_grant     = grant_q;
  assign stats_pkt     = pkt_cnt_q;
  assign stats_sop_err = err_cnt_q;

endmodule

// File: tb/tb_avlstrm_pkt_rr_arbiter.sv
// Directed bench for avlstrm_pkt_rr_arbiter: cycle table for arbitration timing,
// plus packet sequences for backpressure, almost-full, sop errors and reset.
module tb_avlstrm_pkt_rr_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int GW = 2;

  logic              Clk;
  logic              Rst_n;
  logic [NI*DW-1:0]  in_data;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_sop;
  logic [NI-1:0]     in_eop;
  logic [NI*EW-1:0]  in_empty;
  logic [NI-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [EW-1:0]     out_empty;
  logic              out_ready;
  logic              out_almost_full;
  logic [GW-1:0]     cur_grant;
  logic              busy;
  logic [31:0]       stats_pkt;
  logic [31:0]       stats_sop_err;

  avlstrm_pkt_rr_arbiter #(
    .NUM_IN(NI), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .GRANT_W(GW)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready), .out_almost_full(out_almost_full),
    .cur_grant(cur_grant), .busy(busy), .stats_pkt(stats_pkt), .stats_sop_err(stats_sop_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic [3:0] sop;
    logic [3:0] eop;
    logic [3:0] e_rdy;
    bit         e_ov;
    bit         e_osop;
    bit         e_oeop;
    logic [15:0] e_dat;
    logic [1:0] e_gnt;
    bit         e_busy;
    int         e_pkt;
  } vec_t;

  vec_t vq[$];
  int   fidx[NI];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                     input logic [3:0] rdy, input bit ov, input bit osop, input bit oeop,
                     input logic [15:0] dat, input logic [1:0] g, input bit bsy, input int pkt);
    vec_t r;
    r.rst = rst; r.vld = v; r.sop = s; r.eop = e; r.e_rdy = rdy; r.e_ov = ov;
    r.e_osop = osop; r.e_oeop = oeop; r.e_dat = dat; r.e_gnt = g; r.e_busy = bsy; r.e_pkt = pkt;
    vq.push_back(r);
  endtask

  // Flit data carries {tag, source index, flit index within the source's stream}.
  task automatic drive_all(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                           input logic [1:0] emp);
    in_valid = v;
    in_sop   = s;
    in_eop   = e;
    for (int i = 0; i < NI; i++) begin
      in_data[i*DW +: DW]  = {16'hBEEF, 8'(i), 8'(fidx[i])};
      in_empty[i*EW +: EW] = emp;
    end
  endtask

  task automatic run_pkt(input int src, input int n, input logic [1:0] emp,
                         input bit toggle_rdy, input int af_low, input int budget);
    int ocnt, occ, cyc;
    logic tin, tout;
    logic [3:0] v, s, e;
    ocnt = 0; occ = 0; cyc = 0;
    fidx[src] = 0;
    while (ocnt < n && cyc < budget) begin
      v = (fidx[src] < n) ? 4'(1 << src) : 4'b0;
      s = (fidx[src] == 0) ? v : 4'b0;
      e = (fidx[src] == n - 1) ? v : 4'b0;
      drive_all(v, s, e, emp);
      out_ready       = toggle_rdy ? (cyc % 3 == 0) : 1'b1;
      out_almost_full = (af_low >= 0) && (cyc != af_low);
      @(negedge Clk);
      tin  = in_valid[src] & in_ready[src];
      tout = out_valid & out_ready;
      if (busy) chk($sformatf("s%0d_grant", src), 32'(cur_grant), 32'(src));
      if (tout) begin
        chk($sformatf("s%0d_f%0d_data", src, ocnt), out_data, {16'hBEEF, 8'(src), 8'(ocnt)});
        chk($sformatf("s%0d_f%0d_sop", src, ocnt), 32'(out_sop), 32'(ocnt == 0));
        chk($sformatf("s%0d_f%0d_eop", src, ocnt), 32'(out_eop), 32'(ocnt == n - 1));
        if (ocnt == n - 1) chk($sformatf("s%0d_empty", src), 32'(out_empty), 32'(emp));
      end
      @(posedge Clk); #1;
      if (tin) fidx[src]++;
      if (tout) ocnt++;
      occ = occ + int'(tin) - int'(tout);
      chk($sformatf("s%0d_occ_le2", src), 32'(occ > 2 || occ < 0), 32'd0);
      cyc++;
    end
    chk($sformatf("s%0d_flits_out", src), 32'(ocnt), 32'(n));
    drive_all(4'b0, 4'b0, 4'b0, 2'd0);
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      chk($sformatf("s%0d_no_dup", src), 32'(out_valid), 32'd0);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tin_v;
    for (int i = 0; i < NI; i++) fidx[i] = 0;
    Rst_n = 1'b0;
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    drive_all(4'b0, 4'b0, 4'b0, 2'd0);

    // rst, vld, sop, eop | in_ready, ov, osop, oeop, data, grant, busy, stats_pkt
    // Two 3-flit packets on inputs 0 and 2.
    add(1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 2'd3, 0, 0);
    add(1, 4'b0101, 4'b0101, 4'b0000, 4'b0001, 0, 0, 0, 16'h0000, 2'd0, 1, 0);
    add(1, 4'b0101, 4'b0100, 4'b0000, 4'b0001, 1, 1, 0, 16'h0000, 2'd0, 1, 0);
    add(1, 4'b0101, 4'b0100, 4'b0001, 4'b0001, 1, 0, 0, 16'h0001, 2'd0, 1, 0);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1, 0, 1, 16'h0002, 2'd0, 0, 0);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0, 16'h0000, 2'd2, 1, 1);
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 1, 0, 16'h0200, 2'd2, 1, 1);
    add(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 0, 0, 16'h0201, 2'd2, 1, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 16'h0202, 2'd2, 0, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 2'd2, 0, 2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 2'd2, 0, 2);
    // All four inputs offering 1-flit packets back to back.
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 16'h0000, 2'd3, 0, 0);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 0, 0, 0, 16'h0000, 2'd0, 1, 0);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0000, 2'd0, 0, 0);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 0, 0, 0, 16'h0000, 2'd1, 1, 1);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0100, 2'd1, 0, 1);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0100, 0, 0, 0, 16'h0000, 2'd2, 1, 2);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0200, 2'd2, 0, 2);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 0, 0, 0, 16'h0000, 2'd3, 1, 3);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0300, 2'd3, 0, 3);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 0, 0, 0, 16'h0000, 2'd0, 1, 4);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0001, 2'd0, 0, 4);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 0, 0, 0, 16'h0000, 2'd1, 1, 5);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0101, 2'd1, 0, 5);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0100, 0, 0, 0, 16'h0000, 2'd2, 1, 6);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1, 1, 1, 16'h0201, 2'd2, 0, 6);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 0, 0, 0, 16'h0000, 2'd3, 1, 7);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 16'h0301, 2'd3, 0, 7);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 16'h0000, 2'd3, 0, 8);

    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sop_eop_empty", {28'd0, out_sop, out_eop, out_empty}, 32'd0);
    chk("rst_stats_sop_err", stats_sop_err, 32'd0);
    @(posedge Clk); #1;

    for (int k = 0; k < vq.size(); k++) begin
      Rst_n = vq[k].rst;
      drive_all(vq[k].vld, vq[k].sop, vq[k].eop, 2'd0);
      @(negedge Clk);
      chk($sformatf("t%0d_in_ready", k), 32'(in_ready), 32'(vq[k].e_rdy));
      chk($sformatf("t%0d_out_valid", k), 32'(out_valid), 32'(vq[k].e_ov));
      if (vq[k].e_ov) begin
        chk($sformatf("t%0d_out_sop", k), 32'(out_sop), 32'(vq[k].e_osop));
        chk($sformatf("t%0d_out_eop", k), 32'(out_eop), 32'(vq[k].e_oeop));
        chk($sformatf("t%0d_out_data", k), out_data, {16'hBEEF, vq[k].e_dat});
      end
      chk($sformatf("t%0d_cur_grant", k), 32'(cur_grant), 32'(vq[k].e_gnt));
      chk($sformatf("t%0d_busy", k), 32'(busy), 32'(vq[k].e_busy));
      chk($sformatf("t%0d_stats_pkt", k), stats_pkt, 32'(vq[k].e_pkt));
      tin_v = in_valid & in_ready;
      @(posedge Clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (tin_v[i]) fidx[i]++;
        if (!vq[k].rst) fidx[i] = 0;
      end
    end
    Rst_n = 1'b1;

    // 5-flit packet on input 1 with out_ready pattern 1,0,0,1,0,0,...
    run_pkt(1, 5, 2'd2, 1'b1, -1, 60);

    // Almost-full blocks a new grant for input 3.
    fidx[3] = 0;
    drive_all(4'b1000, 4'b1000, 4'b0000, 2'd3);
    out_almost_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      chk($sformatf("af%0d_out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("af%0d_busy", c), 32'(busy), 32'd0);
      chk($sformatf("af%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge Clk); #1;
    end
    // Granted with almost-full low for one cycle, then high for the whole packet.
    run_pkt(3, 4, 2'd3, 1'b0, 0, 40);

    // Two sop-less flits on input 2 while idle are drained and counted.
    drive_all(4'b0100, 4'b0000, 4'b0000, 2'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk($sformatf("drain%0d_in_ready", c), 32'(in_ready), 32'b0100);
      chk($sformatf("drain%0d_out_valid", c), 32'(out_valid), 32'd0);
      @(posedge Clk); #1;
    end
    drive_all(4'b0000, 4'b0000, 4'b0000, 2'd0);
    @(negedge Clk);
    chk("drain_stats_sop_err", stats_sop_err, 32'd2);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    @(posedge Clk); #1;
    run_pkt(2, 3, 2'd1, 1'b0, -1, 40);

    // Reset after the second flit of a 4-flit packet on input 1.
    fidx[1] = 0;
    drive_all(4'b0010, 4'b0010, 4'b0000, 2'd0);
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("mid_in_ready", 32'(in_ready), 32'b0010);
    chk("mid_cur_grant", 32'(cur_grant), 32'd1);
    tin_v = in_valid & in_ready;
    @(posedge Clk); #1;
    if (tin_v[1]) fidx[1]++;
    drive_all(4'b0010, 4'b0000, 4'b0000, 2'd0);
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    drive_all(4'b0000, 4'b0000, 4'b0000, 2'd0);
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    chk("postrst_in_ready", 32'(in_ready), 32'd0);
    chk("postrst_stats_pkt", stats_pkt, 32'd0);
    chk("postrst_stats_sop_err", stats_sop_err, 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_cur_grant", 32'(cur_grant), 32'd3);
    @(posedge Clk); #1;
    run_pkt(3, 2, 2'd1, 1'b0, -1, 40);
    @(negedge Clk);
    chk("final_cur_grant", 32'(cur_grant), 32'd3);
    chk("final_stats_pkt", stats_pkt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
